debounce_scan: RTL and testbench
================================

Name: debounce_scan

Overview:
- Multi-channel debounce controller. One shared filter-update unit is time-multiplexed across N_CH slow inputs such as buttons or limit switches.
- Per-channel state (last sample, stable counter, filtered output) lives in register banks. A prescaled scan FSM visits each channel once per sample tick.
- Sits between raw board inputs and control logic. It replaces N separate per-input filter instances with one scheduler and one update datapath.

Parameters:
- N_CH, 4, number of input channels (2..16).
- CNT_W, 4, width of per-channel stable counter and of thresh.
- PRESCALE, 16, clk cycles per sample tick; must be >= N_CH+2.
- INVERT, 1, 1 = filtered output is inverted (q=0 when input stable high), 0 = non-inverted.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- d  input  N_CH  raw asynchronous inputs.
- thresh  input  CNT_W  stable-sample threshold; captured on each tick.
- q  output  N_CH  filtered outputs.
- chg  output  N_CH  one-cycle pulse on each bit whose q toggled.
- busy  output  1  high while the FSM is in SCAN.
- overrun  output  1  sticky flag; set if a tick occurs while in SCAN.

Behaviour:
- Reset (rst=1 at clk edge):
  - prescale counter=0, FSM=IDLE, scan idx=0, busy=0, overrun=0, chg=0.
  - Every channel: last=0, count=0, q=INVERT (all-ones if INVERT=1).
  - Sync flops are cleared.
  - Reset mid-scan aborts the scan immediately. No partial update survives.
- Input sync: d passes through a 2-flop synchronizer, giving d_s with 2 clk latency.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick=1 in the cycle the count equals PRESCALE-1.
- FSM states: IDLE, SCAN.
  - IDLE: on tick, capture thresh into thr_r, set idx=0, go to SCAN.
  - SCAN: each cycle, update channel idx using d_s[idx]. Then:
    - If idx==N_CH-1: go to IDLE, idx=0.
    - Otherwise: idx=idx+1.
  - busy is a registered copy of (state==SCAN).
- Per-channel update (shared unit, one channel per cycle):
  - d_s[idx]!=last[idx]: last<=d_s[idx], count<=0, q unchanged.
  - else if count<thr_r: count<=count+1.
  - else: q[idx]<=last[idx]^INVERT. If this changes q[idx], chg[idx]=1 for the next cycle only.
  - Counter never wraps; it holds at thr_r.
- Latency: let scan k be the first scan that samples a new stable level. Then q updates at the end of that channel's slot in scan k+thr_r+1.
  - thr_r=0: q updates on scan k+1.
  - Input glitches shorter than one full scan period may be missed entirely. This is intended.
- chg: all bits default 0 each cycle. At most one bit is high per cycle.
- thresh changing mid-scan has no effect until the next tick.
- overrun: a tick arriving while in SCAN sets overrun and is otherwise ignored. overrun clears only on rst. This cannot occur when PRESCALE>=N_CH+2.
- Channels not being visited hold all state.

Decomposition:
- Shared package debounce_pkg holds:
  - FSM state encoding constants ST_IDLE=1'b0, ST_SCAN=1'b1.
  - Default CNT_W.
- One sub-module: debounce_step. It is the combinational next-state function for one channel.
  - Inputs: d_bit, last, count, q, thr, invert.
  - Outputs: last_n, count_n, q_n, toggled.
  - debounce_scan instantiates it once and muxes channel state by idx.

Test Plan (N_CH=4, CNT_W=4, PRESCALE=8, INVERT=1, thresh=3 unless stated):
- Reset, then d=0 held for 10 ticks -> q=4'b1111, chg never asserted, busy high 4 cycles per 8-cycle period, overrun=0.
- d[2] 0->1 and held -> q[2] falls to 0 at the end of ch2's slot in the 5th scan after first sampling. chg=4'b0100 for exactly one cycle. Other bits unchanged.
- d[1] high pulse for 2 scans then low, with thresh=3 -> q[1] stays 1 and chg stays 0; last[1] returns to 0.
- thresh=0, d[3] 0->1 -> q[3]=0 on the second scan; thresh changed to 15 mid-scan -> next scan still uses 0.
- d=4'b1111 simultaneously -> q bits fall on consecutive cycles ch0..ch3 within one scan. chg pulses 0001, 0010, 0100, 1000 in order.
- Assert rst during SCAN at idx=2 with counters nonzero -> next cycle busy=0, q=4'b1111, all counts 0. Then PRESCALE=4 build (N_CH+2 violated) -> overrun goes 1 and stays until rst.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants for the time-multiplexed debounce controller.
package debounce_pkg;

  localparam int unsigned CNT_W_DEF = 4;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SCAN = 1'b1;

  typedef enum logic {
    StIdle = ST_IDLE,
    StScan = ST_SCAN
  } state_e;

endpackage

// File: rtl/debounce_step.sv
// Combinational next-state function for one debounce channel.
module debounce_step
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             d_bit,
  input  logic             last,
  input  logic [CNT_W-1:0] count,
  input  logic             q,
  input  logic [CNT_W-1:0] thr,
  input  logic             invert,
  output logic             last_n,
  output logic [CNT_W-1:0] count_n,
  output logic             q_n,
  output logic             toggled
);

  always_comb begin
    last_n  = last;
    count_n = count;
    q_n     = q;
    if (d_bit != last) begin
      last_n  = d_bit;
      count_n = '0;
    end else if (count < thr) begin
      count_n = count + 1'b1;
    end else begin
      // Counter saturates at thr; output follows the stable level from here on.
      q_n = last ^ invert;
    end
  end

  assign toggled = q_n ^ q;

endmodule

// File: rtl/debounce_scan.sv
// Multi-channel debounce: one shared update unit visits each channel once per sample tick.
module debounce_scan
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned PRESCALE = 16,
  parameter int unsigned INVERT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  d,
  input  logic [CNT_W-1:0] thresh,
  output logic [N_CH-1:0]  q,
  output logic [N_CH-1:0]  chg,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned IDX_W = $clog2(N_CH);
  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic        INV   = (INVERT != 0);

  logic [N_CH-1:0]  d_meta_q, d_s_q;
  logic [PRE_W-1:0] pre_q;
  logic             tick;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic             busy_q;
  logic             ovr_q, ovr_d;

  logic [N_CH-1:0]  last_q, last_d;
  logic [N_CH-1:0]  q_q, q_d;
  logic [N_CH-1:0]  chg_q, chg_d;
  logic [CNT_W-1:0] count_q [N_CH];
  logic [CNT_W-1:0] count_d [N_CH];

  logic             step_last_n, step_q_n, step_toggled;
  logic [CNT_W-1:0] step_count_n;

  assign tick = (pre_q == PRE_W'(PRESCALE - 1));

  debounce_step #(
    .CNT_W(CNT_W)
  ) u_step (
    .d_bit  (d_s_q[idx_q]),
    .last   (last_q[idx_q]),
    .count  (count_q[idx_q]),
    .q      (q_q[idx_q]),
    .thr    (thr_q),
    .invert (INV),
    .last_n (step_last_n),
    .count_n(step_count_n),
    .q_n    (step_q_n),
    .toggled(step_toggled)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    thr_d   = thr_q;
    ovr_d   = ovr_q;
    last_d  = last_q;
    q_d     = q_q;
    count_d = count_q;
    chg_d   = '0;
    case (state_q)
      StIdle: begin
        if (tick) begin
          thr_d   = thresh;
          idx_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        // A tick during a scan is dropped; only the sticky flag records it.
        if (tick) ovr_d = 1'b1;
        last_d[idx_q]  = step_last_n;
        count_d[idx_q] = step_count_n;
        q_d[idx_q]     = step_q_n;
        chg_d[idx_q]   = step_toggled;
        if (idx_q == IDX_W'(N_CH - 1)) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_meta_q <= '0;
      d_s_q    <= '0;
      pre_q    <= '0;
      state_q  <= StIdle;
      idx_q    <= '0;
      thr_q    <= '0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      last_q   <= '0;
      q_q      <= {N_CH{INV}};
      chg_q    <= '0;
      for (int i = 0; i < int'(N_CH); i++) count_q[i] <= '0;
    end else begin
      d_meta_q <= d;
      d_s_q    <= d_meta_q;
      pre_q    <= tick ? '0 : pre_q + 1'b1;
      state_q  <= state_d;
      idx_q    <= idx_d;
      thr_q    <= thr_d;
      busy_q   <= (state_q == StScan);
      ovr_q    <= ovr_d;
      last_q   <= last_d;
      q_q      <= q_d;
      chg_q    <= chg_d;
      count_q  <= count_d;
    end
  end

  assign q       = q_q;
  assign chg     = chg_q;
  assign busy    = busy_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_debounce_scan.sv
// Self-checking bench: scan-level reference model of the debounce rules plus a short-prescale overrun build.
module tb_debounce_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d;
  logic [3:0] thresh;
  logic [3:0] q, chg, q2, chg2;
  logic       busy, ovr, busy2, ovr2;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, advanced once per scan.
  logic [3:0] m_last;
  logic [3:0] m_q;
  int         m_cnt [4];

  always #5 clk = ~clk;

  debounce_scan #(
    .N_CH(4), .CNT_W(4), .PRESCALE(8), .INVERT(1)
  ) dut (
    .clk(clk), .rst(rst), .d(d), .thresh(thresh),
    .q(q), .chg(chg), .busy(busy), .overrun(ovr)
  );

  debounce_scan #(
    .N_CH(4), .CNT_W(4), .PRESCALE(4), .INVERT(1)
  ) dut_ovr (
    .clk(clk), .rst(rst), .d(d), .thresh(thresh),
    .q(q2), .chg(chg2), .busy(busy2), .overrun(ovr2)
  );

  task automatic model_reset();
    m_last = 4'b0000;
    m_q    = 4'b1111;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // Pulses rst for one edge, then returns 4 cycles after release (prescaler phase 4, idle).
  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    if (q !== 4'b1111) begin n_bad++; $display("FAIL reset_q got %b want 1111", q); end
    n_cmp++;
    if (chg !== 4'b0000) begin n_bad++; $display("FAIL reset_chg got %b want 0000", chg); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++;
    if (ovr !== 1'b0) begin n_bad++; $display("FAIL reset_ovr got %b want 0", ovr); end
    n_cmp++;
    if (ovr2 !== 1'b0) begin n_bad++; $display("FAIL reset_ovr2 got %b want 0", ovr2); end
    n_cmp++;
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if ({q, q2} !== 8'hFF) begin
        n_bad++; $display("FAIL post_reset_q c=%0d got %b/%b want 1111", c, q, q2);
      end
      n_cmp++;
      if ({chg, chg2, busy, busy2, ovr, ovr2} !== 12'h000) begin
        n_bad++;
        $display("FAIL post_reset_flags c=%0d chg=%b chg2=%b busy=%b busy2=%b ovr=%b ovr2=%b want 0",
                 c, chg, chg2, busy, busy2, ovr, ovr2);
      end
      n_cmp++;
    end
  endtask

  // One full sample period, entered at phase 4. d/thresh change only while idle.
  task automatic run_period(input logic [3:0] dval, input logic [3:0] thr,
                            input bit mid, input logic [3:0] thr_mid);
    logic [3:0] q_old, q_new, tog, exp_q, exp_chg;
    logic       exp_busy;
    d      = dval;
    thresh = thr;
    q_old  = m_q;
    for (int i = 0; i < 4; i++) begin
      if (dval[i] != m_last[i]) begin
        m_last[i] = dval[i];
        m_cnt[i]  = 0;
      end else if (m_cnt[i] < int'(thr)) begin
        m_cnt[i]++;
      end else begin
        m_q[i] = m_last[i] ^ 1'b1;
      end
    end
    q_new = m_q;
    tog   = q_old ^ q_new;
    // r is the cycle offset from the first slot of the scan (channel r visited at r).
    for (int r = -3; r <= 4; r++) begin
      @(posedge clk); #1;
      if (mid && r == 1) thresh = thr_mid;
      exp_q   = q_old;
      exp_chg = 4'b0000;
      for (int j = 0; j < 4; j++) if (r >= j + 1) exp_q[j] = q_new[j];
      if (r >= 1) exp_chg[r-1] = tog[r-1];
      exp_busy = (r >= 1);
      if (q !== exp_q) begin n_bad++; $display("FAIL q r=%0d got %b want %b", r, q, exp_q); end
      n_cmp++;
      if (chg !== exp_chg) begin
        n_bad++; $display("FAIL chg r=%0d got %b want %b", r, chg, exp_chg);
      end
      n_cmp++;
      if (busy !== exp_busy) begin
        n_bad++; $display("FAIL busy r=%0d got %b want %b", r, busy, exp_busy);
      end
      n_cmp++;
      if (ovr !== 1'b0) begin n_bad++; $display("FAIL overrun r=%0d got %b want 0", r, ovr); end
      n_cmp++;
    end
  endtask

  task automatic test_idle_low();
    for (int p = 0; p < 10; p++) run_period(4'b0000, 4'd3, 1'b0, 4'd0);
  endtask

  task automatic test_single_rise();
    for (int p = 1; p <= 5; p++) begin
      run_period(4'b0100, 4'd3, 1'b0, 4'd0);
      if (p == 4 && q !== 4'b1111) begin
        n_bad++; $display("FAIL rise_scan4 got %b want 1111", q);
      end
      if (p == 4) n_cmp++;
    end
    if (q !== 4'b1011) begin n_bad++; $display("FAIL rise_scan5 got %b want 1011", q); end
    n_cmp++;
    run_period(4'b0100, 4'd3, 1'b0, 4'd0);
  endtask

  task automatic test_glitch();
    run_period(4'b0110, 4'd3, 1'b0, 4'd0);
    run_period(4'b0110, 4'd3, 1'b0, 4'd0);
    for (int p = 0; p < 5; p++) run_period(4'b0100, 4'd3, 1'b0, 4'd0);
    if (q !== 4'b1011) begin n_bad++; $display("FAIL glitch_q got %b want 1011", q); end
    n_cmp++;
  endtask

  task automatic test_thresh_zero();
    run_period(4'b1100, 4'd0, 1'b0, 4'd0);
    if (q[3] !== 1'b1) begin n_bad++; $display("FAIL thr0_scan1 got %b want 1", q[3]); end
    n_cmp++;
    run_period(4'b1100, 4'd0, 1'b1, 4'd15);
    if (q[3] !== 1'b0) begin n_bad++; $display("FAIL thr0_scan2 got %b want 0", q[3]); end
    n_cmp++;
  endtask

  task automatic test_simultaneous();
    test_reset();
    run_period(4'b0000, 4'd3, 1'b0, 4'd0);
    for (int p = 0; p < 5; p++) run_period(4'b1111, 4'd3, 1'b0, 4'd0);
    if (q !== 4'b0000) begin n_bad++; $display("FAIL simul_q got %b want 0000", q); end
    n_cmp++;
  endtask

  task automatic test_random();
    logic [3:0] dv;
    dv = d;
    for (int p = 0; p < 40; p++) begin
      dv = dv ^ 4'($urandom & $urandom);
      run_period(dv, 4'($urandom_range(0, 3)), 1'($urandom), 4'($urandom));
    end
  endtask

  task automatic test_reset_mid_scan();
    for (int p = 0; p < 6; p++) run_period(4'b0101, 4'd3, 1'b0, 4'd0);
    if (q !== 4'b1010) begin n_bad++; $display("FAIL prime_q got %b want 1010", q); end
    n_cmp++;
    for (int r = -3; r <= 2; r++) begin
      @(posedge clk); #1;
    end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL midscan_busy got %b want 1", busy); end
    n_cmp++;
    test_reset();
    // Counters and last samples must restart from zero: five fresh scans to fall again.
    for (int p = 1; p <= 5; p++) begin
      run_period(4'b0101, 4'd3, 1'b0, 4'd0);
      if (p == 4 && q !== 4'b1111) begin
        n_bad++; $display("FAIL after_rst_scan4 got %b want 1111", q);
      end
      if (p == 4) n_cmp++;
    end
    if (q !== 4'b1010) begin n_bad++; $display("FAIL after_rst_scan5 got %b want 1010", q); end
    n_cmp++;
  endtask

  task automatic test_overrun();
    test_reset();
    for (int c = 5; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ovr2 !== (c >= 8)) begin
        n_bad++; $display("FAIL overrun2 c=%0d got %b want %b", c, ovr2, (c >= 8));
      end
      n_cmp++;
    end
    test_reset();
  endtask

  initial begin
    rst    = 1'b1;
    d      = 4'b0000;
    thresh = 4'd3;
    test_reset();
    test_idle_low();
    test_single_rise();
    test_glitch();
    test_thresh_zero();
    test_simultaneous();
    test_random();
    test_reset_mid_scan();
    test_overrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
